// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial modes, per-mode length/tap/mask tables,
// and the word-stepping helpers used by both the generator and the checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_mode_e;

  localparam int unsigned MAX_W = 32;

  // Bit positions of the two feedback taps (exponent minus one) and state masks.
  localparam logic [4:0]  PRBS_HI   [4] = '{5'd6, 5'd14, 5'd22, 5'd30};
  localparam logic [4:0]  PRBS_TAP  [4] = '{5'd5, 5'd13, 5'd17, 5'd27};
  localparam logic [30:0] PRBS_MASK [4] = '{31'h7F, 31'h7FFF, 31'h7FFFFF, 31'h7FFFFFFF};

  typedef struct packed {
    logic [30:0] state;
    logic [31:0] word;
  } prbs_step_t;

  typedef struct packed {
    logic [30:0] state;
    logic [31:0] mism;
  } prbs_chk_t;

  function automatic logic prbs_fb(logic [30:0] s, prbs_mode_e m);
    return s[PRBS_HI[m]] ^ s[PRBS_TAP[m]];
  endfunction

  // Word is LSB-aligned: the first of w steps lands in bit w-1.
  function automatic prbs_step_t lfsr_step_word(logic [30:0] state, prbs_mode_e mode,
                                                int unsigned w);
    prbs_step_t r;
    logic       fb;
    r.state = state;
    r.word  = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        fb      = prbs_fb(r.state, mode);
        r.state = {r.state[29:0], fb} & PRBS_MASK[mode];
        r.word  = {r.word[30:0], fb};
      end
    end
    return r;
  endfunction

  // Self-synchronising compare: predictions come from received bits, not own feedback.
  function automatic prbs_chk_t chk_step_word(logic [30:0] state, prbs_mode_e mode,
                                              int unsigned w, logic [31:0] data);
    prbs_chk_t   r;
    logic [31:0] d;
    logic        rx;
    r.state = state;
    r.mism  = '0;
    d       = data << (MAX_W - w);
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        rx      = d[31];
        d       = {d[30:0], 1'b0};
        r.mism  = {r.mism[30:0], prbs_fb(r.state, mode) ^ rx};
        r.state = {r.state[29:0], rx} & PRBS_MASK[mode];
      end
    end
    return r;
  endfunction

  function automatic logic [5:0] popcnt32(logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker: hunts for LOCK_WORDS clean words, then
// accumulates a saturating bit-error count while locked.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int W          = 14,
  parameter int LOCK_WORDS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  prbs_mode_e   mode_i,
  input  logic         chk_valid_i,
  input  logic [W-1:0] chk_data_i,
  input  logic         clr_cnt_i,
  output logic         locked_o,
  output logic [31:0]  err_cnt_o
);

  // state  | meaning
  // HUNT   | waiting for LOCK_WORDS consecutive clean words; errors not counted
  // LOCKED | tracking the stream; mismatched bits accumulate into err_cnt
  typedef enum logic {HUNT, LOCKED} chk_state_e;

  localparam int CW = $clog2(LOCK_WORDS + 1);

  chk_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [30:0]   reg_q;
  logic [31:0]   err_q;
  logic          locked_q;

  prbs_chk_t     res;
  logic [5:0]    n_mm;
  logic [32:0]   err_sum;

  always_comb begin
    res     = chk_step_word(reg_q, mode_i, W, 32'(chk_data_i));
    n_mm    = popcnt32(res.mism);
    err_sum = {1'b0, err_q} + {27'd0, n_mm};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      reg_q    <= '1;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      if (chk_valid_i) reg_q <= res.state;
      if (load_i) begin
        state_q  <= HUNT;
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else if (chk_valid_i) begin
        unique case (state_q)
          HUNT: begin
            if (n_mm != 6'd0) begin
              cnt_q <= '0;
            end else if (cnt_q == CW'(LOCK_WORDS - 1)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          LOCKED: begin
            if (n_mm > 6'(W / 2)) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
      // Clear wins over a coincident counted error.
      if (clr_cnt_i) begin
        err_q <= '0;
      end else if (!load_i && chk_valid_i && state_q == LOCKED) begin
        err_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
      end
    end
  end

  assign locked_o  = locked_q;
  assign err_cnt_o = err_q;

endmodule

// File: rtl/prbs_gen_chk.sv
// Multi-mode PRBS generator with ready/valid output and seed/mode load.
// The loopback checker is built only when PRBS_CHECKER_EN is defined.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int W          = 14,
  parameter int LOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [30:0]  seed,
  input  logic         inject_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         chk_valid,
  input  logic [W-1:0] chk_data,
  input  logic         clr_cnt,
  output logic         locked,
  output logic [31:0]  err_cnt
);

  logic [30:0] state_q, state_d;
  prbs_mode_e  mode_q, mode_d;
  logic        valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic        inj_q, inj_d;

  prbs_step_t  step;
  logic [30:0] seed_m;
  logic        unused_gen;

  always_comb begin
    step    = lfsr_step_word(state_q, mode_q, W);
    seed_m  = seed & PRBS_MASK[mode];
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    data_d  = data_q;
    inj_d   = inj_q | inject_err;
    if (load) begin
      state_d = (seed_m == '0) ? PRBS_MASK[mode] : seed_m;
      mode_d  = prbs_mode_e'(mode);
      valid_d = 1'b0;
    end else if (en && (!valid_q || out_ready)) begin
      // Corruption touches only the emitted word; the LFSR keeps running clean.
      state_d = step.state;
      data_d  = step.word[W-1:0] ^ W'(inj_q | inject_err);
      valid_d = 1'b1;
      inj_d   = 1'b0;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 31'h7F;
      mode_q  <= PRBS7;
      valid_q <= 1'b0;
      data_q  <= '0;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      inj_q   <= inj_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign unused_gen = ^step.word;

`ifdef PRBS_CHECKER_EN
  prbs_chk #(
    .W          (W),
    .LOCK_WORDS (LOCK_WORDS)
  ) u_chk (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .mode_i      (mode_q),
    .chk_valid_i (chk_valid),
    .chk_data_i  (chk_data),
    .clr_cnt_i   (clr_cnt),
    .locked_o    (locked),
    .err_cnt_o   (err_cnt)
  );
`else
  logic unused_chk;
  assign unused_chk = ^{chk_valid, chk_data, clr_cnt};
  assign locked     = 1'b0;
  assign err_cnt    = '0;
`endif

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised multi-mode PRBS source with a stream handshake and an optional self-synchronising checker. It supersedes the single-polynomial, free-running generator. It adds selectable PRBS7/15/23/31 polynomials, W bits per clock, seed load, error injection, and a lock/error-count checker for link and BIST loopback tests.

## Interface
- W, 14, data word width in bits, 1..32
- LOCK_WORDS, 4, consecutive error-free words needed to declare lock
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  allows new words to be generated
- load  in  1  single-cycle seed/mode load
- mode  in  2  polynomial select, sampled on load
- seed  in  31  initial LFSR state, sampled on load
- inject_err  in  1  inverts bit 0 of the next generated word
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word
- out_data  out  W  generated word
- chk_valid  in  1  received word strobe (checker)
- chk_data  in  W  received word (checker)
- clr_cnt  in  1  clears err_cnt (checker)
- locked  out  1  checker locked (checker)
- err_cnt  out  32  saturating bit-error count (checker)

## Operation
- Polynomials, with n = register length:
  - mode 0: x^7+x^6+1, n=7
  - mode 1: x^15+x^14+1, n=15
  - mode 2: x^23+x^18+1, n=23
  - mode 3: x^31+x^28+1, n=31
- LFSR step:
  - feedback fb = s[n-1] ^ s[tap-1], where tap is the second exponent.
  - Next state s = {s[29:0], fb} masked to n bits.
  - The output bit is fb.
- Word assembly:
  - W steps are taken per word.
  - The first step goes to out_data[W-1], the last to out_data[0].
- Load:
  - state <= seed masked to n bits.
  - A masked seed of 0 is replaced by all-ones (no lock-up).
  - The mode is latched and out_valid is cleared.
  - Load has priority over everything else.
- Generation:
  - A new word is registered when en=1 and (out_valid=0 or out_ready=1). out_valid is then set to 1.
  - When out_valid=1, out_ready=0 and en=0, out_valid stays at 1 and out_data stays stable.
  - out_valid falls only on a transfer with en=0, or on load.
- inject_err:
  - Sticky request until the next generated word.
  - That word has bit 0 inverted; the LFSR state itself is not corrupted.
- Checker:
  - Uses the latched mode.
  - On each chk_valid it predicts W bits from its register and compares them with chk_data, MSB first.
  - It then shifts the received bits into its register (self-synchronising), so one line error yields 3 mismatches.
  - State HUNT: counts consecutive words with zero mismatches. Reaching LOCK_WORDS moves it to LOCKED. Any mismatch resets the count.
  - State LOCKED: err_cnt += popcount(mismatches), saturating at 32'hFFFFFFFF. A word with more than W/2 mismatches returns it to HUNT. err_cnt is not counted in HUNT.
  - load forces HUNT.
  - clr_cnt zeroes err_cnt. If clr_cnt and a counted error coincide, the result is 0.

## Timing
- Reset values:
  - out_valid=0, out_data=0
  - mode=0, state=7'h7F
  - locked=0, err_cnt=0, checker in HUNT with count 0
- Latency:
  - load sampled at edge k: first new word visible after edge k+1 (if en=1).
  - Reset released: first word visible after the first edge with en=1.
- Checker:
  - locked rises the edge that accepts the LOCK_WORDS-th clean word.
  - err_cnt updates one edge after the erroneous chk_valid.
- Reset mid-stream discards the pending word immediately (asynchronous).

## Configuration
- PRBS_CHECKER_EN defined: the checker is built and its ports are live.
- PRBS_CHECKER_EN undefined:
  - The checker is absent.
  - The chk_* and clr_cnt inputs are ignored.
  - locked is tied to 0 and err_cnt to 0.
  - The generator is unchanged.

## Structure
- Package prbs_pkg holds:
  - the prbs_mode_e enum (PRBS7, PRBS15, PRBS23, PRBS31)
  - the length and tap constant arrays
  - a function lfsr_step_word(state, mode, W) returning the next state and word
- The checker is the sub-module prbs_chk, sharing the package function.

## Test plan
- Reset, then en=1 and out_ready=1 with mode 0 default: first out_data=14'h0083. The sequence repeats every 127 bits.
- load seed=0 with mode=3: behaves as the all-ones seed. out_valid is low for one cycle, then valid the next.
- out_ready=0 for 5 cycles while valid: out_data is stable and out_valid stays 1. The next word appears after the ready edge.
- Loopback out_data into chk_data with mode 1: locked=1 after 4 words and err_cnt stays 0.
- Once locked, pulse inject_err once: err_cnt=3, locked stays 1. Then clr_cnt gives err_cnt=0.
- Feed constant 14'h3FFF while locked: checker drops to HUNT and locked=0. Release reset mid-run and check all reset values.
